npc_ctrl: RTL
=============

NPC_CTRL -- requirements
Module: npc_ctrl

Interface
REQ-001 The block SHALL provide: clk  input  1  rising-edge clock.
REQ-002 The block SHALL provide: reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL provide: pc  input  32  current fetch PC from the fetch-stage PC register.
REQ-004 The block SHALL provide: stall  input  1  pipeline freeze request from hazard unit.
REQ-005 The block SHALL provide: br_valid  input  1  one-cycle pulse, branch/jump in D resolved.
REQ-006 The block SHALL provide: br_taken  input  1  taken qualifier, sampled only with br_valid.
REQ-007 The block SHALL provide: br_target  input  32  branch/jump target.
REQ-008 The block SHALL provide: eret  input  1  one-cycle pulse, eret resolved in D.
REQ-009 The block SHALL provide: epc  input  32  return address, sampled only with eret.
REQ-010 The block SHALL provide: Req  input  1  exception/interrupt entry request from CP0.
REQ-011 The block SHALL provide: next_pc  output  32  value loaded into the PC register.
REQ-012 The block SHALL provide: pc_en  output  1  PC register load enable.
REQ-013 The block SHALL provide: d_bd  output  1  instruction in D is a branch delay slot.
REQ-014 The block SHALL provide: f_adel  output  1  current fetch address illegal.
REQ-015 The block SHALL provide: redir_cnt  output  16  saturating count of PC redirects.
REQ-016 The block SHALL provide parameter EXC_ENTRY, default 32'h0000_4180, handler address.
REQ-017 The block SHALL provide parameter PC_LO, default 32'h0000_3000, and PC_HI, default 32'h0000_6FFC, legal fetch range.

Function
REQ-018 Redirect priority per cycle SHALL be: Req > eret > taken branch > pending redirect > sequential (pc+4).
REQ-019 Req=1 SHALL force next_pc=EXC_ENTRY and pc_en=1 in the same cycle, ignoring stall, clearing any pending redirect and returning the FSM to RUN.
REQ-020 The FSM SHALL have two states: RUN (no pending redirect) and HOLD (redirect latched, waiting for stall release).
REQ-021 In RUN with stall=0: pc_en=1; next_pc=epc if eret, else br_target if br_valid&br_taken, else pc+4 (32-bit, wrap ignored).
REQ-022 In RUN with stall=1 and (eret or br_valid&br_taken): pc_en=0, the redirect address (eret priority) SHALL be latched into a pending register and the FSM SHALL go to HOLD next cycle.
REQ-023 In RUN with stall=1 and no redirect: pc_en=0, next_pc=pc+4, state unchanged.
REQ-024 In HOLD with stall=1: pc_en=0, next_pc=pending, pending held.
REQ-025 In HOLD with stall=0: pc_en=1, next_pc=pending, FSM to RUN next cycle.
REQ-026 In HOLD, a new eret or br_valid pulse SHALL overwrite the pending address (eret priority); latency to PC unchanged.
REQ-027 br_valid with br_taken=0 SHALL produce no redirect; pc+4 path applies.
REQ-028 d_bd SHALL update only when pc_en=1: d_bd <= br_valid (taken or not) & ~Req; d_bd <= 0 when Req=1; held while pc_en=0.
REQ-029 f_adel SHALL be combinational: 1 when pc[1:0]!=0 or pc<PC_LO or pc>PC_HI, else 0.
REQ-030 redir_cnt SHALL increment by 1 on every cycle with pc_en=1 and next_pc!=pc+4 due to Req, eret, branch or pending, saturating at 16'hFFFF.
REQ-031 next_pc SHALL be purely combinational from inputs and state; no extra cycle of latency on any redirect path.

Reset
REQ-032 On reset=1 at a clock edge: state=RUN, pending=0, d_bd=0, redir_cnt=0; reset SHALL dominate Req and all other inputs.
REQ-033 While reset=1, pc_en SHALL be 1 and next_pc SHALL follow REQ-018..REQ-021 (PC register itself forces 32'h0000_3000).
REQ-034 Reset during HOLD SHALL discard the pending redirect.

Verification
REQ-035 pc=0x3000, no stall, no events, 3 cycles -> next_pc 0x3004, pc_en=1, redir_cnt=0.
REQ-036 pc=0x3010, br_valid=br_taken=1, br_target=0x3100, stall=0 -> next_pc=0x3100, pc_en=1; next cycle d_bd=1, redir_cnt=1.
REQ-037 stall=1 for 3 cycles with br pulse target 0x3200 in cycle 1 -> pc_en=0 for 3 cycles, HOLD; stall drops -> next_pc=0x3200, pc_en=1, then RUN.
REQ-038 HOLD with pending 0x3200, Req=1 while stall=1 -> next_pc=0x4180, pc_en=1, state RUN, d_bd=0, pending discarded.
REQ-039 Same cycle Req=1, eret=1 (epc=0x3040), br taken -> next_pc=0x4180; eret alone with branch -> next_pc=0x3040.
REQ-040 pc=0x3002 -> f_adel=1; pc=0x7000 -> f_adel=1; pc=0x6FFC -> f_adel=0; redir_cnt preloaded to 0xFFFF via 65535 redirects stays 0xFFFF.

Source files
------------

// File: rtl/npc_ctrl.sv
// npc_ctrl: next-PC selection with stall-deferred redirects, delay-slot flag, fetch address check and redirect counter
module npc_ctrl #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] PC_LO     = 32'h0000_3000,
  parameter logic [31:0] PC_HI     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        Req,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic        d_bd,
  output logic        f_adel,
  output logic [15:0] redir_cnt
);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0]  state;
  logic [31:0] pending, seq, redir_addr;
  logic        redir, chg;
  assign seq        = pc + 32'd4;
  assign redir      = eret | (br_valid & br_taken);
  assign redir_addr = eret ? epc : br_target;
  assign f_adel     = (pc[1:0] != 2'b00) | (pc < PC_LO) | (pc > PC_HI);
  always_comb begin
    next_pc = Req ? EXC_ENTRY : redir ? redir_addr : (state == HOLD) ? pending : seq;
    pc_en   = reset | Req | ~stall;
    chg     = (Req | redir | (state == HOLD)) & (next_pc != seq);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pending   <= '0;
      d_bd      <= 1'b0;
      redir_cnt <= '0;
    end else begin
      if (pc_en) d_bd <= br_valid & ~Req;
      if (pc_en && chg && redir_cnt != 16'hFFFF) redir_cnt <= redir_cnt + 16'd1;
      // a redirect arriving under stall is parked until the stall releases
      if (Req) begin
        state   <= RUN;
        pending <= '0;
      end else if (stall && redir) begin
        state   <= HOLD;
        pending <= redir_addr;
      end else if (!stall) begin
        state <= RUN;
      end
    end
  end
endmodule
